// File: rtl/arb_out_queue_pkg.sv
// Shared defaults, the queue entry layout, and pointer/count widths for the arbiter output queue.
package arb_out_queue_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int TAG_W_DEF  = 2;

    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF  = PTR_W_DEF + 1;
    localparam int ENT_W_DEF  = TAG_W_DEF + DATA_W_DEF;

    // One queued arbiter grant: the chosen source index travels with its payload.
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/arb_out_queue_ram.sv
// Entry storage for the arbiter output queue: synchronous write, combinational read, no reset.
module queue_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the incoming entry into the addressed slot; contents are never cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/arb_out_queue.sv
// Output queue behind an arbiter: buffers {tag, data} grants in arrival order.
// Ready depends only on fullness and valid only on emptiness, so neither handshake
// side forms a combinational path to the other.
module arb_out_queue
    import arb_out_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_enq_valid,
    output logic                   io_enq_ready,
    input  logic [DATA_W-1:0]      io_enq_bits_data,
    input  logic [TAG_W-1:0]       io_enq_bits_tag,
    output logic                   io_deq_valid,
    input  logic                   io_deq_ready,
    output logic [DATA_W-1:0]      io_deq_bits_data,
    output logic [TAG_W-1:0]       io_deq_bits_tag,
    output logic [$clog2(DEPTH):0] io_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + DATA_W;

    logic [PTR_W-1:0] r_enq_ptr;
    logic [PTR_W-1:0] r_deq_ptr;
    logic             r_maybe_full;

    logic             w_ptr_match;
    logic             w_full;
    logic             w_empty;
    logic             w_enq_fire;
    logic             w_deq_fire;
    logic             w_ram_we;
    logic [PTR_W-1:0] w_diff;
    logic [ENT_W-1:0] w_wr_entry;
    logic [ENT_W-1:0] w_rd_entry;

    assign w_ptr_match  = (r_enq_ptr == r_deq_ptr);
    assign w_full       = w_ptr_match &&  r_maybe_full;
    assign w_empty      = w_ptr_match && !r_maybe_full;

    assign io_enq_ready = !w_full;
    assign io_deq_valid = !w_empty;

    assign w_enq_fire   = io_enq_valid && io_enq_ready;
    assign w_deq_fire   = io_deq_valid && io_deq_ready;

    // A fire during the reset cycle must leave no trace, including in storage.
    assign w_ram_we     = w_enq_fire && !reset;
    assign w_wr_entry   = {io_enq_bits_tag, io_enq_bits_data};

    queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_enq_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_deq_ptr),
        .o_rdata (w_rd_entry)
    );

    assign io_deq_bits_tag  = w_rd_entry[ENT_W-1:DATA_W];
    assign io_deq_bits_data = w_rd_entry[DATA_W-1:0];

    // Pointer difference wraps modulo DEPTH; equal pointers mean DEPTH when full.
    assign w_diff   = r_enq_ptr - r_deq_ptr;
    assign io_count = w_full ? CNT_W'(DEPTH) : {1'b0, w_diff};

    // Advance pointers on each fire and track whether equal pointers mean full or empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                r_enq_ptr <= r_enq_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_deq_ptr <= r_deq_ptr + 1'b1;
            end
            if (w_enq_fire != w_deq_fire) begin
                r_maybe_full <= w_enq_fire;
            end
        end
    end

endmodule

// File: doc/arb_out_queue.md
ARB_OUT_QUEUE -- requirements
Module: arb_out_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-002 Parameter DATA_W, default 8, payload width.
REQ-003 Parameter TAG_W, default 2, source-index width, equal to the upstream arbiter's chosen width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with the ports named clk and reset.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- io_enq_valid  in  1  arbiter output valid.
- io_enq_ready  out  1  queue can accept.
- io_enq_bits_data  in  DATA_W  arbiter output payload.
- io_enq_bits_tag  in  TAG_W  arbiter chosen index.
- io_deq_valid  out  1  head entry present.
- io_deq_ready  in  1  consumer accepts.
- io_deq_bits_data  out  DATA_W  head payload.
- io_deq_bits_tag  out  TAG_W  head tag.
- io_count  out  log2(DEPTH)+1  occupancy.

Function
REQ-006 Enqueue fire: io_enq_valid & io_enq_ready. Dequeue fire: io_deq_valid & io_deq_ready.
REQ-007 io_enq_ready SHALL be !full. It SHALL NOT depend combinationally on io_deq_ready, so a full queue accepts nothing even while dequeuing.
REQ-008 io_deq_valid SHALL be !empty. It SHALL NOT depend combinationally on io_enq_valid, so there is no flow-through.
REQ-009 State SHALL be enq_ptr and deq_ptr (log2(DEPTH) bits each, wrapping modulo DEPTH) plus a maybe_full flag.
- empty = ptrs equal and !maybe_full.
- full = ptrs equal and maybe_full.
REQ-010 On enqueue fire, {data, tag} SHALL be written at enq_ptr and enq_ptr incremented. On dequeue fire, deq_ptr SHALL be incremented.
REQ-011 maybe_full SHALL be set when an enqueue fires without a dequeue, cleared when a dequeue fires without an enqueue, and held otherwise.
REQ-012 io_deq_bits SHALL be a combinational read of the entry at deq_ptr. An entry enqueued in cycle N SHALL be first visible on deq in cycle N+1 (latency 1).
REQ-013 Simultaneous enqueue and dequeue fire (0 < count < DEPTH) SHALL leave count unchanged and preserve FIFO order.
REQ-014 io_count SHALL equal (enq_ptr - deq_ptr) mod DEPTH, or DEPTH when full.
REQ-015 Entries SHALL leave in arrival order with data and tag bound together. No entry is dropped or duplicated.
REQ-016 io_deq_bits SHALL be don't-care while io_deq_valid = 0.
REQ-017 io_enq_bits changes while io_enq_ready = 0 SHALL have no effect.

Reset
REQ-018 While reset = 1 at a clk edge, enq_ptr, deq_ptr and maybe_full SHALL clear to 0. The cycle after reset: io_enq_ready = 1, io_deq_valid = 0, io_count = 0.
REQ-019 Storage SHALL NOT be reset. Reset asserted mid-operation discards all contents, and any fire in the reset cycle is ignored.

Structure
REQ-020 A shared package SHALL hold DEPTH, DATA_W and TAG_W defaults, the entry struct {tag, data}, and the pointer and count width constants.
REQ-021 Storage SHALL be one sub-module, queue_ram: DEPTH x (TAG_W+DATA_W), synchronous write, combinational read.
REQ-022 The pointer, flag and handshake logic SHALL reside in arb_out_queue. It SHALL have no latches and no combinational loop from io_deq_ready to io_enq_ready.

Verification
REQ-023 Scenario — after reset, enqueue {tag 2, data 0x5A} in cycle 0 with deq_ready = 0:
- Cycle 1: deq_valid = 1, bits {2, 0x5A}, count = 1.
REQ-024 Scenario — fill 4 entries (0x10..0x13) with deq_ready = 0:
- count = 4 and enq_ready = 0.
- A 5th enq_valid with 0xFF is not accepted.
- Draining yields 0x10, 0x11, 0x12, 0x13.
REQ-025 Scenario — full queue, deq_ready = 1 and enq_valid = 1 in the same cycle:
- Only the dequeue fires, so count goes 4 -> 3.
- The enqueue is accepted in the next cycle.
REQ-026 Scenario — count = 2, enq and deq both firing for 10 cycles:
- count stays 2.
- Output sequence equals input sequence delayed by 2 entries.
- Pointers wrap past DEPTH without error.
REQ-027 Scenario — reset asserted with count = 3:
- Next cycle count = 0, deq_valid = 0, enq_ready = 1.
- Old data never reappears.
REQ-028 Scenario — random enq_valid/deq_ready for 10,000 cycles, fed by a 4-input priority arbiter:
- Scoreboard matches order and {tag, data}.
- Invariant count <= 4 holds throughout.
